// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the IR immediate field selected by in_mode
// into a DATA_W-bit operand behind a valid/ready handshake. Define IMM_SKID_EN for a 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHIFT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [2:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_err
);

    localparam int unsigned FIELD_W = 26;

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic              err;
    } entry_t;

    // Immediate decode; only instr[25:0] ever feeds an immediate.
    function automatic entry_t decode(input logic [FIELD_W-1:0] instr, input logic [2:0] mode);
        entry_t             e;
        logic signed [15:0] half;
        logic signed [31:0] upper;
        half  = instr[15:0];
        upper = {instr[15:0], 16'h0000};
        e.imm = '0;
        e.err = 1'b0;
        case (mode)
            3'b000:  e.imm = DATA_W'(half);
            3'b001:  e.imm = DATA_W'(half) << SHIFT_W;
            3'b010:  e.imm = DATA_W'(instr[25:0]) << SHIFT_W;
            3'b011:  e.imm = DATA_W'(instr[10:6]);
            3'b100:  e.imm = DATA_W'(instr[15:0]);
            3'b101:  e.imm = DATA_W'(upper);
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    entry_t in_entry;
    logic   accept;
    logic   unused_instr_hi;

    assign in_entry        = decode(in_instr[FIELD_W-1:0], in_mode);
    assign accept          = in_valid && in_ready;
    assign unused_instr_hi = ^in_instr[31:FIELD_W];

`ifdef IMM_SKID_EN
    logic   skid_valid;
    entry_t skid_q;

    assign in_ready = !skid_valid;

    // Main register refills from skid first so ordering is preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_imm    <= skid_q.imm;
                out_err    <= skid_q.err;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_imm <= in_entry.imm;
                    out_err <= in_entry.err;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_q     <= in_entry;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    // Single stage: load whenever the register is free or being drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_err   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_imm <= in_entry.imm;
                out_err <= in_entry.err;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: 32- and 64-bit instances share stimulus;
// expectations come from directed constants or an arithmetic reference model.
module tb_imm_gen_pipe;

    localparam int SHIFT = 2;
`ifdef IMM_SKID_EN
    localparam int BP_ACC = 2;
`else
    localparam int BP_ACC = 1;
`endif
    localparam logic [63:0] T2 [6] = '{
        64'hFFFF_FFFF_FFFF_8004, 64'hFFFF_FFFF_FFFE_0010, 64'h0000_0000_0002_0010,
        64'h0000_0000_0000_0000, 64'h0000_0000_0000_8004, 64'hFFFF_FFFF_8004_0000};

    logic        clk, rst_n, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_mode;
    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;

    typedef struct {
        logic [63:0] e64;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          xfers  = 0;
    logic        held;
    logic [33:0] saved;

    imm_gen_pipe #(.DATA_W(32), .SHIFT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_mode(in_mode), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_err(out_err32));

    imm_gen_pipe #(.DATA_W(64), .SHIFT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_mode(in_mode), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_err(out_err64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: immediates as plain signed/unsigned integer arithmetic.
    function automatic logic [63:0] model(input logic [31:0] instr, input logic [2:0] mode,
                                          output logic err);
        longint  v;
        shortint s;
        int      t;
        s   = instr[15:0];
        err = 1'b0;
        case (mode)
            3'd0: v = s;
            3'd1: v = s * (1 << SHIFT);
            3'd2: v = longint'(instr[25:0]) * (1 << SHIFT);
            3'd3: v = (instr >> 6) % 32;
            3'd4: v = instr % 65536;
            3'd5: begin
                t = int'(instr[15:0]) * 65536;
                v = t;
            end
            default: begin
                v   = 0;
                err = 1'b1;
            end
        endcase
        return v;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] md,
                        input logic rdy, input logic [63:0] e64, input logic e_err,
                        output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        in_mode   = md;
        out_ready = rdy;
        @(negedge clk);
        acc = v && in_ready32 && rst_n;
        if (acc) begin
            e.e64 = e64;
            e.err = e_err;
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic rand_step(input logic v, input logic rdy, output logic acc);
        logic [31:0] ins;
        logic [2:0]  md;
        logic [63:0] e64;
        logic        er;
        ins = $urandom;
        md  = 3'($urandom_range(0, 7));
        e64 = model(ins, md, er);
        step(v, ins, md, rdy, e64, er, acc);
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] md,
                        input logic [63:0] e64, input logic er);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, ins, md, 1'b1, e64, er, acc);
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step(1'b0, 32'h0, 3'd0, 1'b1, 64'h0, 1'b0, acc);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops on every output transfer, and checks outputs hold while stalled.
    initial begin
        exp_t e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) chk("stall_hold", 64'({out_valid32, out_err32, out_imm32}), 64'(saved));
                if (out_valid32 && out_ready) begin
                    xfers++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got imm %h with empty scoreboard at %0t",
                                 out_imm32, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("imm32", 64'(out_imm32), 64'(e.e64[31:0]));
                        chk("err32", 64'(out_err32), 64'(e.err));
                        chk("imm64", out_imm64, e.e64);
                        chk("err64", 64'(out_err64), 64'(e.err));
                        chk("valid64", 64'(out_valid64), 64'd1);
                    end
                end
                held  = out_valid32 && !out_ready;
                saved = {out_valid32, out_err32, out_imm32};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   acc_cnt;
        int   x0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hDEAD_BEEF;
        in_mode   = 3'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid32", 64'(out_valid32), 64'd0);
        chk("rst_imm32", 64'(out_imm32), 64'd0);
        chk("rst_err32", 64'(out_err32), 64'd0);
        chk("rst_valid64", 64'(out_valid64), 64'd0);
        chk("rst_imm64", out_imm64, 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_reset32", 64'(in_ready32), 64'd1);
        chk("ready_after_reset64", 64'(in_ready64), 64'd1);
        #1;

        for (int i = 0; i < 6; i++) send(32'h0000_8004, 3'(i), T2[i], 1'b0);
        drain();

        send(32'h0000_8004, 3'd6, 64'h0, 1'b1);
        send(32'hFFFF_FFFF, 3'd7, 64'h0, 1'b1);
        send(32'h0000_1234, 3'd0, 64'h0000_0000_0000_1234, 1'b0);
        drain();

        acc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            rand_step(1'b1, 1'b0, acc);
            acc_cnt += int'(acc);
        end
        chk("bp_accepted", 64'(acc_cnt), 64'(BP_ACC));
        chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
        for (int i = 0; i < 20 && acc_cnt < 4; i++) begin
            rand_step(1'b1, 1'b1, acc);
            acc_cnt += int'(acc);
        end
        chk("bp_total", 64'(acc_cnt), 64'd4);
        drain();

        x0      = xfers;
        acc_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            rand_step(1'b1, 1'b1, acc);
            acc_cnt += int'(acc);
        end
        step(1'b0, 32'h0, 3'd0, 1'b1, 64'h0, 1'b0, acc);
        chk("tp_accepted", 64'(acc_cnt), 64'd16);
        chk("tp_outputs", 64'(xfers - x0), 64'd16);
        drain();

        for (int i = 0; i < 24; i++) rand_step(1'b1, 1'(i % 2), acc);
        drain();

        send(32'hABCD_8000, 3'd0, 64'hFFFF_FFFF_FFFF_8000, 1'b0);
        drain();

        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0, acc);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 3'd0, 1'b1, 64'h0, 1'b0, acc);
            chk("post_reset_idle32", 64'(out_valid32), 64'd0);
            chk("post_reset_idle64", 64'(out_valid64), 64'd0);
        end

        for (int i = 0; i < 300; i++) rand_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7), acc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
